// File: rtl/apb_initiator.sv
// apb_initiator: single-outstanding valid/ready request channel to APB4 SETUP/ACCESS transfers with timeout
module apb_initiator #(
    parameter  int XLEN    = 64,
    parameter  int ADDR_W  = 28,
    parameter  int NUM_SLV = 4,
    parameter  int TIMEOUT = 255,
    localparam int SEL_W   = NUM_SLV > 1 ? $clog2(NUM_SLV) : 1,
    localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ReqValid,
    output logic                ReqReady,
    input  logic                ReqWrite,
    input  logic [SEL_W-1:0]    ReqSel,
    input  logic [ADDR_W-1:0]   ReqAddr,
    input  logic [XLEN-1:0]     ReqWData,
    input  logic [XLEN/8-1:0]   ReqStrb,
    output logic                RspValid,
    output logic [XLEN-1:0]     RspData,
    output logic                RspErr,
    output logic [NUM_SLV-1:0]  PSEL,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [ADDR_W-1:0]   PADDR,
    output logic [XLEN-1:0]     PWDATA,
    output logic [XLEN/8-1:0]   PSTRB,
    input  logic [XLEN-1:0]     PRDATA,
    input  logic                PREADY,
    input  logic                PSLVERR
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               sel_ok;
    logic [NUM_SLV-1:0] sel_hot;
    logic               timeout_hit;

    // Decode the completer index and flag the ACCESS cycle whose wait would make the counter reach TIMEOUT.
    always_comb begin
        sel_ok      = 32'(ReqSel) < 32'(NUM_SLV);
        sel_hot     = sel_ok ? NUM_SLV'(1) << ReqSel : '0;
        timeout_hit = 32'(cnt) + 32'd1 == 32'(TIMEOUT);
    end

    // Phase sequencer; every output is a register so PREADY/PRDATA never reach an output combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            ReqReady <= 1'b1;
            RspValid <= 1'b0;
            RspData  <= '0;
            RspErr   <= 1'b0;
            PSEL     <= '0;
            PENABLE  <= 1'b0;
            PWRITE   <= 1'b0;
            PADDR    <= '0;
            PWDATA   <= '0;
            PSTRB    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ReqValid) begin
                        ReqReady <= 1'b0;
                        PWRITE   <= ReqWrite;
                        PADDR    <= ReqAddr;
                        PWDATA   <= ReqWData;
                        PSTRB    <= ReqWrite ? ReqStrb : '0;
                        PSEL     <= sel_hot;
                        RspValid <= !sel_ok;
                        RspErr   <= !sel_ok;
                        RspData  <= '0;
                        state    <= sel_ok ? SETUP : RESP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    cnt     <= '0;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        PSEL     <= '0;
                        PENABLE  <= 1'b0;
                        RspValid <= 1'b1;
                        RspErr   <= PSLVERR;
                        RspData  <= PWRITE ? '0 : PRDATA;
                        state    <= RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (timeout_hit) begin
                            PSEL     <= '0;
                            PENABLE  <= 1'b0;
                            RspValid <= 1'b1;
                            RspErr   <= 1'b1;
                            RspData  <= '0;
                            state    <= RESP;
                        end
                    end
                end
                RESP: begin
                    RspValid <= 1'b0;
                    RspErr   <= 1'b0;
                    RspData  <= '0;
                    ReqReady <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_initiator.sv
// tb_apb_initiator: table-driven directed bench for apb_initiator with hand-written reset sequences
module tb_apb_initiator;
    localparam int XLEN    = 64;
    localparam int ADDR_W  = 28;
    localparam int NUM_SLV = 3;
    localparam int TIMEOUT = 4;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                ReqValid = 1'b0;
    logic                ReqReady;
    logic                ReqWrite = 1'b0;
    logic [1:0]          ReqSel = '0;
    logic [ADDR_W-1:0]   ReqAddr = '0;
    logic [XLEN-1:0]     ReqWData = '0;
    logic [XLEN/8-1:0]   ReqStrb = '0;
    logic                RspValid;
    logic [XLEN-1:0]     RspData;
    logic                RspErr;
    logic [NUM_SLV-1:0]  PSEL;
    logic                PENABLE;
    logic                PWRITE;
    logic [ADDR_W-1:0]   PADDR;
    logic [XLEN-1:0]     PWDATA;
    logic [XLEN/8-1:0]   PSTRB;
    logic [XLEN-1:0]     PRDATA = '0;
    logic                PREADY = 1'b0;
    logic                PSLVERR = 1'b0;

    always #5 clk = ~clk;

    apb_initiator #(.XLEN(XLEN), .ADDR_W(ADDR_W), .NUM_SLV(NUM_SLV), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite), .ReqSel(ReqSel),
        .ReqAddr(ReqAddr), .ReqWData(ReqWData), .ReqStrb(ReqStrb),
        .RspValid(RspValid), .RspData(RspData), .RspErr(RspErr),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    typedef struct {
        logic              write;
        logic [1:0]        sel;
        logic [ADDR_W-1:0] addr;
        logic [XLEN-1:0]   wdata;
        logic [7:0]        strb;
        int                waits;
        logic [XLEN-1:0]   prdata;
        logic              pslverr;
        logic [2:0]        exp_psel;
        logic [7:0]        exp_pstrb;
        int                exp_en;
        int                exp_lat;
        logic              exp_err;
        logic [XLEN-1:0]   exp_data;
    } vec_t;

    vec_t vecs[8];
    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One request from presentation to the idle cycle after its response, with a modelled completer.
    task automatic run_vec(input vec_t v, input int k);
        int en;
        int lat;
        en  = 0;
        lat = 0;
        @(negedge clk);
        chk($sformatf("v%0d ready_idle", k), ReqReady, 1);
        ReqValid = 1'b1; ReqWrite = v.write; ReqSel = v.sel; ReqAddr = v.addr;
        ReqWData = v.wdata; ReqStrb = v.strb;
        PREADY = 1'b0; PSLVERR = 1'b1; PRDATA = ~v.prdata;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                ReqValid = 1'b0; ReqWrite = ~v.write; ReqSel = 2'd0;
                ReqAddr = '1; ReqWData = '1; ReqStrb = '1;
            end
            if (RspValid) lat = c;
            else begin
                chk($sformatf("v%0d c%0d psel", k, c), PSEL, v.exp_psel);
                chk($sformatf("v%0d c%0d paddr", k, c), PADDR, v.addr);
                if (c == 1) begin
                    chk($sformatf("v%0d setup penable", k), PENABLE, 0);
                    chk($sformatf("v%0d setup pwrite", k), PWRITE, v.write);
                    chk($sformatf("v%0d setup pstrb", k), PSTRB, v.exp_pstrb);
                    chk($sformatf("v%0d setup ready", k), ReqReady, 0);
                    if (v.write) chk($sformatf("v%0d setup pwdata", k), PWDATA, v.wdata);
                end
                if (PENABLE) begin
                    en++;
                    PREADY  = (en == v.waits + 1);
                    PSLVERR = PREADY ? v.pslverr : 1'b1;
                    PRDATA  = PREADY ? v.prdata : ~v.prdata;
                end
            end
        end
        PREADY = 1'b0; PSLVERR = 1'b1; PRDATA = 64'h0BAD_0BAD_0BAD_0BAD;
        chk($sformatf("v%0d latency", k), lat, v.exp_lat);
        chk($sformatf("v%0d access_cycles", k), en, v.exp_en);
        chk($sformatf("v%0d rsp_err", k), RspErr, v.exp_err);
        chk($sformatf("v%0d rsp_data", k), RspData, v.exp_data);
        chk($sformatf("v%0d resp psel", k), PSEL, 0);
        chk($sformatf("v%0d resp penable", k), PENABLE, 0);
        @(negedge clk);
        chk($sformatf("v%0d rsp_pulse", k), RspValid, 0);
        chk($sformatf("v%0d ready_again", k), ReqReady, 1);
        PSLVERR = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rv_seen;
        //          wr    sel   addr          wdata                  strb   waits prdata                 err   psel    pstrb  en lat eerr  edata
        vecs[0] = '{1'b1, 2'd0, 28'h0200000, 64'h3,                 8'h0F, 0,   64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3'b001, 8'h0F, 1, 3, 1'b0, 64'h0};
        vecs[1] = '{1'b0, 2'd1, 28'h0200004, 64'h55,                8'hFF, 3,   64'h0000000A_0000000A,   1'b0, 3'b010, 8'h00, 4, 6, 1'b0, 64'h0000000A_0000000A};
        vecs[2] = '{1'b0, 2'd2, 28'h0000010, 64'h0,                 8'h00, 1,   64'hDEADBEEF_12345678,   1'b1, 3'b100, 8'h00, 2, 4, 1'b1, 64'hDEADBEEF_12345678};
        vecs[3] = '{1'b0, 2'd0, 28'h0000020, 64'h0,                 8'h00, 99,  64'h1234,                1'b0, 3'b001, 8'h00, 4, 6, 1'b1, 64'h0};
        vecs[4] = '{1'b1, 2'd1, 28'h0FFFFFC, 64'h11223344_55667788, 8'hF0, 2,   64'h7777,                1'b0, 3'b010, 8'hF0, 3, 5, 1'b0, 64'h0};
        vecs[5] = '{1'b1, 2'd3, 28'h0000040, 64'h99,                8'hFF, 0,   64'h0,                   1'b0, 3'b000, 8'h00, 0, 1, 1'b1, 64'h0};
        vecs[6] = '{1'b1, 2'd2, 28'h0000044, 64'hA5,                8'h01, 0,   64'hCAFE,                1'b1, 3'b100, 8'h01, 1, 3, 1'b1, 64'h0};
        vecs[7] = '{1'b0, 2'd2, 28'h0000048, 64'h0,                 8'h00, 3,   64'h80000000_00000001,   1'b0, 3'b100, 8'h00, 4, 6, 1'b0, 64'h80000000_00000001};

        repeat (2) @(negedge clk);
        chk("rst ReqReady", ReqReady, 1);
        chk("rst RspValid", RspValid, 0);
        chk("rst RspData", RspData, 0);
        chk("rst RspErr", RspErr, 0);
        chk("rst PSEL", PSEL, 0);
        chk("rst PENABLE", PENABLE, 0);
        chk("rst PWRITE", PWRITE, 0);
        chk("rst PADDR", PADDR, 0);
        chk("rst PWDATA", PWDATA, 0);
        chk("rst PSTRB", PSTRB, 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Reset during the second ACCESS cycle of a waited read.
        @(negedge clk);
        ReqValid = 1'b1; ReqWrite = 1'b0; ReqSel = 2'd1; ReqAddr = 28'h0200008; ReqStrb = 8'hFF;
        PREADY = 1'b0;
        @(negedge clk);
        ReqValid = 1'b0;
        chk("mid setup psel", PSEL, 3'b010);
        @(negedge clk);
        chk("mid access1 penable", PENABLE, 1);
        @(negedge clk);
        chk("mid access2 penable", PENABLE, 1);
        reset = 1'b1;
        #1;
        chk("mid async psel", PSEL, 0);
        chk("mid async penable", PENABLE, 0);
        chk("mid async ready", ReqReady, 1);
        @(negedge clk);
        reset = 1'b0;
        PREADY = 1'b1;
        rv_seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (RspValid) rv_seen++;
        end
        PREADY = 1'b0;
        chk("mid no_rsp", rv_seen, 0);
        chk("mid psel_idle", PSEL, 0);

        run_vec(vecs[0], 8);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
